// File: rtl/fmap_window_scanner.sv
// fmap_window_scanner: raster-scans one feature-map channel and presents the
// top-left address and output coordinates of each KxK window, one per cycle,
// holding the current window while the consumer stalls.
module fmap_window_scanner #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 10,
    parameter int CRD_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              all_done,
    output logic              win_valid,
    output logic [ADDR_W-1:0] base_addr,
    output logic [CRD_W-1:0]  out_row,
    output logic [CRD_W-1:0]  out_col,
    output logic              channel_done,
    output logic              busy
);

    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

    localparam logic [CRD_W-1:0]  LAST_COL = CRD_W'(OUT_W - 1);
    localparam logic [CRD_W-1:0]  LAST_ROW = CRD_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              win_valid_q;
    logic              channel_done_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [CRD_W-1:0]  row_q;
    logic [CRD_W-1:0]  col_q;

    logic accept;
    logic at_last_col;
    logic at_last_row;

    // Window handshake and end-of-row / end-of-map detection.
    always_comb begin
        accept      = win_valid_q && !stall;
        at_last_col = (col_q == LAST_COL);
        at_last_row = (row_q == LAST_ROW);
    end

    // Scan FSM; row_base_q tracks column 0 of the current row so the address
    // advances by adds only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            win_valid_q    <= 1'b0;
            channel_done_q <= 1'b0;
            busy_q         <= 1'b0;
            addr_q         <= '0;
            row_base_q     <= '0;
            row_q          <= '0;
            col_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !all_done) begin
                        state_q     <= S_SCAN;
                        win_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        addr_q      <= '0;
                        row_base_q  <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                    end
                end
                S_SCAN: begin
                    if (accept) begin
                        if (!at_last_col) begin
                            col_q  <= col_q + 1'b1;
                            addr_q <= addr_q + COL_STEP;
                        end else if (!at_last_row) begin
                            col_q      <= '0;
                            row_q      <= row_q + 1'b1;
                            addr_q     <= row_base_q + ROW_STEP;
                            row_base_q <= row_base_q + ROW_STEP;
                        end else begin
                            state_q        <= S_DONE;
                            win_valid_q    <= 1'b0;
                            channel_done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q        <= S_IDLE;
                    channel_done_q <= 1'b0;
                    busy_q         <= 1'b0;
                    addr_q         <= '0;
                    row_base_q     <= '0;
                    row_q          <= '0;
                    col_q          <= '0;
                end
                default: begin
                    state_q        <= S_IDLE;
                    win_valid_q    <= 1'b0;
                    channel_done_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign win_valid    = win_valid_q;
    assign base_addr    = addr_q;
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign channel_done = channel_done_q;
    assign busy         = busy_q;

endmodule
